// File: rtl/oam_dma_pkg.sv
// Shared OAM DMA memory-map constants and engine state encoding.
// Used by the DMA engine, the MMU and the GPU register readback.
package oam_dma_pkg;

    localparam logic [15:0] DMA_REG   = 16'hFF46;
    localparam logic [15:0] OAM_BASE  = 16'hFE00;
    localparam logic [15:0] HRAM_BASE = 16'hFF80;
    localparam int          OAM_LEN   = 160;
    localparam int          START_DLY = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } dma_state_t;

endpackage

// File: rtl/oam_dma_if.sv
// Simple byte bus: address, write strobe/data, read strobe/data.
// The master drives the request, the slave returns read data.
interface oam_dma_if;
    import oam_dma_pkg::*;

    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic        rd;
    logic [7:0]  rdata;

    modport master (
        output addr, we, wdata, rd,
        input  rdata
    );

    modport slave (
        input  addr, we, wdata, rd,
        output rdata
    );

endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: copies page P00-P9F into FE00-FE9F on a write to
// the DMA register, owning the MMU bus and fencing the CPU meanwhile.
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter int          OAM_SIZE     = OAM_LEN,
    parameter logic [15:0] DMA_REG_ADDR = DMA_REG,
    parameter int          START_DELAY  = START_DLY
) (
    input  logic              clk,
    input  logic              rst_n,
    oam_dma_if.slave          cpu,
    oam_dma_if.master         mmu,
    output logic [7:0]        dma_reg,
    output logic              dma_busy,
    output logic [7:0]        dbg_data
);

    localparam logic [7:0] LAST = 8'(OAM_SIZE - 1);
    localparam logic [7:0] DLY_LAST =
        (START_DELAY > 0) ? 8'(START_DELAY - 1) : 8'd0;

    dma_state_t state, state_n;
    logic [7:0] idx;
    logic [7:0] page;
    logic [7:0] dly;
    logic [7:0] data_q;
    logic       trig;
    logic       last;
    logic       dly_done;

    // Trigger is decoded in every state so a busy write restarts the copy.
    assign trig     = cpu.we && (cpu.addr == DMA_REG_ADDR);
    assign last     = (idx == LAST);
    assign dly_done = (dly == DLY_LAST);
    assign dma_busy = (state != ST_IDLE);
    assign dbg_data = data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= 8'd0;
            page    <= 8'd0;
            dly     <= 8'd0;
            dma_reg <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state <= state_n;
            if (trig) begin
                page    <= cpu.wdata;
                dma_reg <= cpu.wdata;
                idx     <= 8'd0;
                dly     <= 8'd0;
            end else begin
                if (state == ST_START)
                    dly <= dly + 8'd1;
                if (state == ST_WRITE && !last)
                    idx <= idx + 8'd1;
            end
            if (state == ST_WRITE)
                data_q <= mmu.rdata;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE:  state_n = ST_IDLE;
            ST_START: if (dly_done) state_n = ST_READ;
            ST_READ:  state_n = ST_WRITE;
            ST_WRITE: state_n = last ? ST_IDLE : ST_READ;
            default:  state_n = ST_IDLE;
        endcase
        if (trig)
            state_n = ST_START;
    end

    always_comb begin
        mmu.addr  = cpu.addr;
        mmu.we    = cpu.we;
        mmu.wdata = cpu.wdata;
        mmu.rd    = cpu.rd;
        cpu.rdata = mmu.rdata;
        if (state != ST_IDLE) begin
            // Engine owns the bus: every CPU access, HRAM included, is fenced.
            cpu.rdata = 8'hFF;
            mmu.addr  = 16'h0000;
            mmu.we    = 1'b0;
            mmu.wdata = 8'h00;
            mmu.rd    = 1'b0;
        end
        unique case (state)
            ST_READ: begin
                mmu.addr = {page, idx};
                mmu.rd   = 1'b1;
            end
            ST_WRITE: begin
                mmu.addr  = OAM_BASE + {8'h00, idx};
                mmu.wdata = mmu.rdata;
                mmu.we    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: a byte-memory MMU model plus an
// expected-write queue compared against every DMA write to OAM.
module tb_oam_dma;
    import oam_dma_pkg::*;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] dma_reg;
    logic       dma_busy;
    logic [7:0] dbg_data;

    oam_dma_if cpu ();
    oam_dma_if mmu ();

    oam_dma dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu      (cpu.slave),
        .mmu      (mmu.master),
        .dma_reg  (dma_reg),
        .dma_busy (dma_busy),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          c050_wr = 0;
    int          oob = 0;
    logic [15:0] last_wa = 16'h0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // MMU model: synchronous write, read data valid one cycle after address
    always @(posedge clk) begin
        if (mmu.we)
            mem[mmu.addr] = mmu.wdata;
        mmu.rdata <= mem[mmu.addr];
    end

    always @(negedge clk) begin
        wr_t e;
        if (dma_busy && mmu.we) begin
            if (mmu.addr == 16'hC050)
                c050_wr++;
            if (mmu.addr >= 16'hFEA0 && mmu.addr < 16'hFF00)
                oob++;
            last_wa = mmu.addr;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_oam_write", {8'h0, mmu.addr, mmu.wdata},
                      {8'h0, e.a, e.d});
            end
        end
    end

    task automatic push_page(input logic [7:0] p);
        exp_q.delete();
        wr_cnt = 0;
        for (int i = 0; i < OAM_LEN; i++)
            exp_q.push_back('{a: OAM_BASE + 16'(i), d: mem[{p, 8'(i)}]});
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        cpu.addr  = a;
        cpu.wdata = d;
        cpu.we    = 1'b1;
        @(posedge clk);
        #1;
        cpu.we = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!dma_busy)
                break;
            n++;
        end
    endtask

    task automatic wait_writes(input int n);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            if (wr_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok)
            check("wait_writes_timeout", 32'd0, 32'd1);
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 256; i++)
            mem[16'hFE00 + 16'(i)] = 8'h00;
    endtask

    initial begin
        int n;
        int bad;
        cpu.addr  = 16'h0;
        cpu.we    = 1'b0;
        cpu.wdata = 8'h0;
        cpu.rd    = 1'b0;
        rst_n     = 1'b0;
        for (int i = 0; i < 65536; i++)
            mem[i] = 8'h00;
        mem[16'hC123] = 8'hAB;
        mem[16'h8000] = 8'h12;
        for (int i = 0; i < OAM_LEN; i++) begin
            mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
            mem[16'hD000 + 16'(i)] = 8'(i) ^ 8'h3C;
        end

        // Reset held with an active trigger write
        @(posedge clk);
        #1;
        cpu.addr  = 16'hFF46;
        cpu.wdata = 8'h33;
        cpu.we    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(dma_busy), 32'd0);
        check("reset_dma_reg", 32'(dma_reg), 32'h00);
        cpu.we = 1'b0;
        rst_n  = 1'b1;
        cpu.addr = 16'hC123;
        cpu.rd   = 1'b1;
        #1;
        check("idle_pass_addr", 32'(mmu.addr), 32'hC123);
        check("idle_pass_rd", 32'(mmu.rd), 32'd1);
        @(posedge clk);
        #1;
        check("idle_read_data", 32'(cpu.rdata), 32'hAB);
        cpu.rd = 1'b0;

        // Full copy from page C0
        clear_oam();
        cpu_write(16'hFF46, 8'hC0);
        push_page(8'hC0);
        check("trig_busy", 32'(dma_busy), 32'd1);
        check("trig_forwarded", 32'(mem[16'hFF46]), 32'hC0);
        count_busy(n);
        check("full_busy_cycles", 32'(n), 32'd321);
        check("full_write_count", 32'(wr_cnt), 32'd160);
        check("final_write_addr", 32'(last_wa), 32'hFE9F);
        check("no_write_past_oam", 32'(oob), 32'd0);
        check("fea0_untouched", 32'(mem[16'hFEA0]), 32'h00);
        check("full_queue_empty", 32'(exp_q.size()), 32'd0);
        check("full_dma_reg", 32'(dma_reg), 32'hC0);
        for (int i = 0; i < OAM_LEN; i++)
            check("full_oam_byte", 32'(mem[16'hFE00 + 16'(i)]),
                  32'(8'(i) ^ 8'h5A));

        // CPU fencing during a transfer
        clear_oam();
        cpu_write(16'hFF46, 8'hC0);
        push_page(8'hC0);
        repeat (10) @(posedge clk);
        #1;
        cpu.addr  = 16'hC050;
        cpu.wdata = 8'h77;
        cpu.we    = 1'b1;
        @(posedge clk);
        #1;
        cpu.we   = 1'b0;
        cpu.addr = 16'h8000;
        cpu.rd   = 1'b1;
        #1;
        check("fence_read_8000", 32'(cpu.rdata), 32'hFF);
        cpu.addr = 16'hFF80;
        #1;
        check("fence_read_hram", 32'(cpu.rdata), 32'hFF);
        cpu.rd = 1'b0;
        count_busy(n);
        check("fence_no_c050_write", 32'(c050_wr), 32'd0);
        check("fence_c050_kept", 32'(mem[16'hC050]), 32'(8'h50 ^ 8'h5A));
        check("fence_oam50", 32'(mem[16'hFE50]), 32'(8'h50 ^ 8'h5A));
        check("fence_queue_empty", 32'(exp_q.size()), 32'd0);

        // Restart mid-transfer onto page D0
        clear_oam();
        cpu_write(16'hFF46, 8'hC0);
        push_page(8'hC0);
        wait_writes(40);
        cpu_write(16'hFF46, 8'hD0);
        push_page(8'hD0);
        check("restart_busy", 32'(dma_busy), 32'd1);
        count_busy(n);
        check("restart_busy_cycles", 32'(n), 32'd321);
        check("restart_write_count", 32'(wr_cnt), 32'd160);
        check("restart_dma_reg", 32'(dma_reg), 32'hD0);
        check("restart_queue_empty", 32'(exp_q.size()), 32'd0);
        bad = 0;
        for (int i = 0; i < OAM_LEN; i++)
            if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'h3C))
                bad++;
        check("restart_oam_mismatches", 32'(bad), 32'd0);

        // Reset in the middle of a transfer
        clear_oam();
        cpu_write(16'hFF46, 8'hC0);
        push_page(8'hC0);
        wait_writes(100);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("midreset_busy", 32'(dma_busy), 32'd0);
        check("midreset_dma_reg", 32'(dma_reg), 32'h00);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midreset_write_count", 32'(wr_cnt), 32'd100);
        check("midreset_fe63", 32'(mem[16'hFE63]), 32'(8'h63 ^ 8'h5A));
        check("midreset_fe64", 32'(mem[16'hFE64]), 32'h00);
        check("midreset_no_oob", 32'(oob), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
